// File: rtl/dxm_mux_seq.sv
// dxm_mux_seq: registered NUM_IN:1 valid/ready channel mux with deferred channel switching.
//
// Selects one of NUM_IN source channels and forwards its beats through a single-entry output
// register to one sink. A channel switch, requested with sel_load, is applied only after the
// output register has drained. No beat is dropped, duplicated or mixed across channels.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   enable      1 = forwarding allowed; 0 = drain the held beat, then go idle
//   sel         requested channel index, captured on sel_load
//   sel_load    one-cycle strobe; a later strobe overwrites an unserviced one
//   in_data     channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready (combinational from state, out_valid, out_ready)
//   out_data    registered output data
//   out_valid   output register holds a beat
//   out_ready   sink accepts the beat
//   cur_sel     active channel index
//   busy        FSM not idle, or a beat is still held
//   sel_err     (only with DXM_MUX_SEQ_ERR_EN) sticky error flag, cleared only by rst
//
// Optional feature macro: DXM_MUX_SEQ_ERR_EN. When it is defined, sel_err is added. It sets on
// an out-of-range sel_load, or when a stalled non-selected channel drops its valid.
module dxm_mux_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_load,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    busy
`ifdef DXM_MUX_SEQ_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             sel_in_range;
  logic             load_ok;
  logic             slot_free;
  logic             apply;
  logic             cur_valid;
  logic [WIDTH-1:0] cur_data;
  logic             xfer;

  assign sel_in_range = (32'(sel) < NUM_IN);
  assign load_ok      = sel_load & sel_in_range;
  // The output register can take a new beat if it is empty or being emptied this cycle.
  assign slot_free    = !out_valid_q || out_ready;

  // Source mux on the active channel.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (cur_sel_q == SEL_W'(k)) begin
        cur_valid = in_valid[k];
        cur_data  = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = (state_q == StRun) && cur_valid && slot_free;

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. 'apply' marks the cycle a pending switch takes effect.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          apply   = pend_vld_q;
        end
      end
      StRun: begin
        // A beat accepted in this cycle is still captured by the output register.
        if (pend_vld_q || !enable) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (slot_free) begin
          state_d = enable ? StRun : StIdle;
          apply   = pend_vld_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      in_ready[k] = (state_q == StRun) && (cur_sel_q == SEL_W'(k)) && slot_free;
    end
    busy = (state_q != StIdle) || out_valid_q;
  end

  // Select bookkeeping. A switch being applied uses the older pend_sel, and a request strobed
  // in that same cycle stays pending for the next drain.
  always_comb begin
    cur_sel_d  = apply ? pend_sel_q : cur_sel_q;
    pend_sel_d = pend_sel_q;
    pend_vld_d = pend_vld_q;
    if (load_ok) begin
      pend_sel_d = sel;
      pend_vld_d = 1'b1;
    end else if (apply) begin
      pend_vld_d = 1'b0;
    end
  end

  // Output register.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = cur_data;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sel_q   <= '0;
      pend_sel_q  <= '0;
      pend_vld_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cur_sel_q   <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      pend_vld_q  <= pend_vld_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;

`ifdef DXM_MUX_SEQ_ERR_EN
  logic [NUM_IN-1:0] stall_q;
  logic [NUM_IN-1:0] unsel;
  logic              drop;
  logic              sel_err_q, sel_err_d;

  always_comb begin
    unsel = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      unsel[k] = (cur_sel_q != SEL_W'(k));
    end
  end

  // A channel that was stalled last cycle and has now withdrawn valid broke its handshake.
  assign drop      = |(stall_q & ~in_valid & unsel);
  assign sel_err_d = sel_err_q || (sel_load && !sel_in_range) || drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      stall_q   <= in_valid & ~in_ready;
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule
